// File: rtl/no_of_1s.sv
// Serial population count: captures a WIDTH-bit word, then counts its set bits
// one per clock, and publishes the total on a registered output.
module no_of_1s #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic [WIDTH-1:0] d_in,
    input  logic             clk,
    input  logic             reset_n,
    output logic [CNT_W-1:0] d_out
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [0:0] LOAD = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    logic [0:0]       state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] acc;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] acc_next;

    // The final count is acc plus the last bit, so it lands on d_out on the
    // same edge that finishes the scan and no partial value is ever visible.
    assign acc_next = acc + CNT_W'(shreg[0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= LOAD;
            shreg <= '0;
            acc   <= '0;
            idx   <= '0;
            d_out <= '0;
        end else begin
            case (state)
                LOAD: begin
                    shreg <= d_in;
                    acc   <= '0;
                    idx   <= '0;
                    state <= SCAN;
                end
                SCAN: begin
                    acc   <= acc_next;
                    shreg <= shreg >> 1;
                    idx   <= idx + IDX_W'(1);
                    if (idx == LAST_IDX) begin
                        d_out <= acc_next;
                        state <= LOAD;
                    end
                end
                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_no_of_1s.sv
// Directed testbench for no_of_1s: hand-computed ones-counts checked at exact
// update edges, plus reset behaviour and input changes during a scan.
module tb_no_of_1s;

    localparam int WIDTH = 16;
    localparam int CNT_W = 5;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [WIDTH-1:0] d_in;
    logic [CNT_W-1:0] d_out;

    int compared   = 0;
    int mismatched = 0;

    no_of_1s #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .d_in    (d_in),
        .clk     (clk),
        .reset_n (reset_n),
        .d_out   (d_out)
    );

    always #10 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [CNT_W-1:0] observed,
                               input logic [CNT_W-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drives the word, then advances the given number of rising edges,
    // returning on the following falling edge where outputs are sampled.
    task automatic applyStimulus(input logic [WIDTH-1:0] word, input int cycles);
        d_in = word;
        repeat (cycles) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic resetDut(input logic [WIDTH-1:0] word);
        @(negedge clk);
        reset_n = 1'b0;
        d_in    = word;
        #2;
        checkOutput("reset_dout", d_out, '0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CNT_W-1:0] prev;
        reset_n = 1'b0;
        d_in    = '0;

        // All-zero word: output stays 0 throughout
        resetDut(16'h0000);
        for (int i = 0; i < 20; i++) begin
            applyStimulus(16'h0000, 1);
            checkOutput("zero_word", d_out, 5'd0);
        end

        // 0x03F2 has 7 ones; first update exactly 17 edges after release
        resetDut(16'h03F2);
        applyStimulus(16'h03F2, 16);
        checkOutput("pre_first_update", d_out, 5'd0);
        applyStimulus(16'h03F2, 1);
        checkOutput("first_update_03f2", d_out, 5'd7);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(16'h03F2, 8);
            checkOutput("hold_03f2_mid", d_out, 5'd7);
            applyStimulus(16'h03F2, 9);
            checkOutput("hold_03f2_rewrite", d_out, 5'd7);
        end

        // Full word: count of 16 must not wrap
        resetDut(16'hFFFF);
        applyStimulus(16'hFFFF, 17);
        checkOutput("full_word", d_out, 5'd16);
        applyStimulus(16'hFFFF, 17);
        checkOutput("full_word_again", d_out, 5'd16);

        // Input changes mid-scan are ignored until the next LOAD
        resetDut(16'h8001);
        applyStimulus(16'h8001, 6);
        applyStimulus(16'hFFFF, 11);
        checkOutput("ignore_midscan", d_out, 5'd2);
        applyStimulus(16'hFFFF, 16);
        checkOutput("hold_before_next", d_out, 5'd2);
        applyStimulus(16'hFFFF, 1);
        checkOutput("next_word_full", d_out, 5'd16);

        // Asynchronous reset mid-scan clears d_out immediately
        resetDut(16'h03F2);
        applyStimulus(16'h03F2, 17);
        checkOutput("steady_before_reset", d_out, 5'd7);
        applyStimulus(16'h03F2, 5);
        #3;
        reset_n = 1'b0;
        #1;
        checkOutput("async_reset_immediate", d_out, 5'd0);
        @(negedge clk);
        checkOutput("reset_held", d_out, 5'd0);
        reset_n = 1'b1;
        applyStimulus(16'h03F2, 16);
        checkOutput("post_reset_pending", d_out, 5'd0);
        applyStimulus(16'h03F2, 1);
        checkOutput("post_reset_count", d_out, 5'd7);

        // Alternating words aligned to LOAD: 1, 8, 1, 8 every 17 cycles
        resetDut(16'h0001);
        prev = 5'd0;
        for (int w = 0; w < 4; w++) begin
            logic [WIDTH-1:0] word;
            logic [CNT_W-1:0] expv;
            word = (w % 2 == 1) ? 16'h00FF : 16'h0001;
            expv = (w % 2 == 1) ? 5'd8 : 5'd1;
            applyStimulus(word, 16);
            checkOutput("alt_hold_prev", d_out, prev);
            applyStimulus(word, 1);
            checkOutput("alt_update", d_out, expv);
            prev = expv;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/no_of_1s.md
Name: no_of_1s

Overview:
- Sequential population-count block: samples a WIDTH-bit input word and counts its set bits serially, one bit per clock.
- Publishes the count on a registered output that holds until the next count completes.
- Runs free and continuously, with no handshake. Used wherever a low-area, multi-cycle ones-count of a status or data word is acceptable.

Parameters:
- WIDTH, 16, input word width in bits (≥2).
- CNT_W, 5, output count width; must satisfy 2^CNT_W > WIDTH (clog2(WIDTH+1)).

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset_n  input  1  reset, asynchronous and active-low.
- d_in  input  WIDTH  word to be counted; sampled only in the LOAD state.
- d_out  output  CNT_W  number of 1s in the most recently completed word; registered.
- Positional instantiation order is fixed: d_in, clk, reset_n, d_out.

Behaviour:
- Internal state:
  - shift register shreg[WIDTH-1:0]
  - accumulator acc[CNT_W-1:0]
  - bit index idx[clog2(WIDTH)-1:0]
  - 1-bit state, LOAD or SCAN
- Reset (reset_n=0, asynchronous, takes effect immediately regardless of clk):
  - d_out=0, acc=0, shreg=0, idx=0, state=LOAD.
  - Held for as long as reset_n is low.
- LOAD, one cycle: on the rising edge, shreg<=d_in, acc<=0, idx<=0, state<=SCAN. d_out is unchanged.
- SCAN, WIDTH cycles: each rising edge does acc<=acc+shreg[0], shreg<=shreg>>1 (zero fill), idx<=idx+1.
- When idx==WIDTH-1 in SCAN:
  - the same edge loads d_out<=acc+shreg[0], which is the final count;
  - state<=LOAD.
- Throughput: one word per WIDTH+1 cycles (17 for default).
- Latency: d_out reflects a word WIDTH cycles after the LOAD edge that captured it.
- d_out is stable between update edges and never shows partial counts.
- d_in changes during SCAN are ignored. A word is counted exactly as captured at the LOAD edge.
- Arithmetic: the adder is CNT_W bits wide. Maximum count WIDTH (16 = 5'b10000) must be representable, with no wrap.
- If d_in is constant, d_out settles after the first update and is rewritten with the same value every WIDTH+1 cycles. There is no glitch on rewrite.
- Reset asserted mid-SCAN:
  - the partial count is discarded and d_out goes to 0 immediately;
  - after release, operation restarts at LOAD on the first rising edge.
- Reset release coincident with a clock edge: that edge may or may not be taken as the LOAD edge. Both are acceptable; the result appears within WIDTH+2 cycles of release.
- No X propagation: all registers are reset; no latches.

Test Plan:
- Reset asserted with d_in=16'h0000, released, clock run for 20 cycles -> d_out=0 throughout.
- d_in=16'b0000001111110010 (0x03F2) applied at reset release, clk period 20 ns -> d_out=7 within 18 cycles (before 500 ns) and held at 7 thereafter.
- d_in=16'hFFFF -> d_out=16 (5'b10000) after one full LOAD+SCAN period; no wrap to 0.
- d_in=16'h8001 loaded, then changed to 16'hFFFF 5 cycles into SCAN -> first update d_out=2. The next update, after 17 more cycles, gives d_out=16.
- Steady d_out=7, then reset_n pulsed low mid-SCAN (between clock edges) -> d_out=0 immediately. After release with d_in=0x03F2, d_out=7 again within WIDTH+2 cycles.
- Alternating words 0x0001 and 0x00FF, each held for exactly 17 cycles aligned to LOAD -> d_out sequence 1, 8, 1, 8, with each update exactly 17 cycles apart.
